// File: rtl/riscv_fetch_ctrl.sv
// riscv_fetch_ctrl: instruction-fetch sequencer.
// Drives the IMEM word address and buffers {pc, instr} pairs in a small prefetch FIFO
// that feeds IF/ID. It also handles decode back-pressure, redirect-with-flush, and
// halting on the STOP word (32'h00000000) or on an out-of-range fetch address.
// Optional feature macro: FETCH_PERF_EN (adds the fetched-word and stall-cycle counters).

module riscv_fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter int          IMEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_a,
    input  logic [31:0] imem_rd,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        halted,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stalls
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [31:0] STOP_WORD = 32'h0000_0000;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    state_t           state;
    logic [31:0]      fetch_pc;
    entry_t           fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic empty;
    logic full;
    logic in_range;
    logic push;
    logic pop;

    // The redirect target is always word aligned, so its two low bits are dropped.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(FIFO_DEPTH));
    assign in_range = ({2'b00, fetch_pc[31:2]} < 32'(IMEM_WORDS));

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign pop  = !empty && !stall && !redirect_valid;
    assign push = (state == RUN) && (!full || pop) && !redirect_valid && in_range;

    assign imem_a   = fetch_pc;
    assign if_valid = !empty;
    assign if_instr = empty ? 32'h0 : fifo_mem[rd_ptr].instr;
    assign if_pc    = empty ? 32'h0 : fifo_mem[rd_ptr].pc;
    assign halted   = (state == HALT) && empty;

    // Fetch FSM: advance the fetch address on each push and stop on STOP or out of range.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            fetch_pc <= RESET_PC;
        end else if (redirect_valid) begin
            state    <= RUN;
            fetch_pc <= {redirect_pc[31:2], 2'b00};
        end else if (state == RUN) begin
            if (!in_range) begin
                state <= HALT;
            end else if (push) begin
                // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
                fetch_pc <= fetch_pc + 32'd4;
                if (imem_rd == STOP_WORD) begin
                    state <= HALT;
                end
            end
        end
    end

    // FIFO bookkeeping: a redirect flushes the FIFO; otherwise it tracks push and pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (redirect_valid) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage: capture the fetched word together with its address.
    always_ff @(posedge clk) begin
        // NOTE: entry storage has no reset; the head outputs are masked to zero while count is zero.
        if (push) begin
            fifo_mem[wr_ptr] <= '{pc: fetch_pc, instr: imem_rd};
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] fetched_q;
    logic [31:0] stalls_q;

    // Performance counters wrap freely and are cleared only by reset, not by a redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetched_q <= '0;
            stalls_q  <= '0;
        end else begin
            if (push) begin
                fetched_q <= fetched_q + 32'd1;
            end
            if (if_valid && stall) begin
                stalls_q <= stalls_q + 32'd1;
            end
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_stalls  = stalls_q;
`else
    assign perf_fetched = 32'h0;
    assign perf_stalls  = 32'h0;
`endif

endmodule

// File: tb/tb_riscv_fetch_ctrl.sv
// Self-checking bench for riscv_fetch_ctrl (FIFO_DEPTH=2, IMEM_WORDS=64, RESET_PC=0).
// A queue-based reference model predicts the outputs after every clock edge.

module tb_riscv_fetch_ctrl;

    localparam int DEPTH = 2;
    localparam int WORDS = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_a;
    logic [31:0] imem_rd;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        halted;
    logic [31:0] perf_fetched;
    logic [31:0] perf_stalls;

    logic [31:0] imem [WORDS];

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc;
    bit          m_stop;
    logic [31:0] m_fetched;
    logic [31:0] m_stalls;

    int checks = 0;
    int errors = 0;

    riscv_fetch_ctrl #(
        .RESET_PC  (32'h0),
        .FIFO_DEPTH(DEPTH),
        .IMEM_WORDS(WORDS)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_a        (imem_a),
        .imem_rd       (imem_rd),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .if_valid      (if_valid),
        .if_instr      (if_instr),
        .if_pc         (if_pc),
        .halted        (halted),
        .perf_fetched  (perf_fetched),
        .perf_stalls   (perf_stalls)
    );

    always #5 clk = ~clk;

    assign imem_rd = (imem_a[31:2] < 30'(WORDS)) ? imem[imem_a[7:2]] : 32'h0;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    // Fill IMEM with random words; roughly one in zero_one_in words is the STOP word (0 = never).
    task automatic fill_imem(input int zero_one_in);
        for (int i = 0; i < WORDS; i++) begin
            if (zero_one_in != 0 && $urandom_range(0, zero_one_in - 1) == 0)
                imem[i] = 32'h0;
            else
                imem[i] = $urandom | 32'h1;
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc      = 32'h0;
        m_stop    = 1'b0;
        m_fetched = 32'h0;
        m_stalls  = 32'h0;
    endtask

    // One clock edge of the reference model, using the inputs currently being driven.
    task automatic model_edge();
        bit had_valid;
        had_valid = (mq.size() != 0);
        if (had_valid && stall) m_stalls = m_stalls + 1;
        if (redirect_valid) begin
            mq.delete();
            m_pc   = {redirect_pc[31:2], 2'b00};
            m_stop = 1'b0;
        end else begin
            if (had_valid && !stall) void'(mq.pop_front());
            if (!m_stop) begin
                if ((m_pc >> 2) >= WORDS) begin
                    m_stop = 1'b1;
                end else if (mq.size() < DEPTH) begin
                    ent_t e;
                    e.pc    = m_pc;
                    e.instr = imem[m_pc[7:2]];
                    mq.push_back(e);
                    m_fetched = m_fetched + 1;
                    m_pc      = m_pc + 4;
                    if (e.instr == 32'h0) m_stop = 1'b1;
                end
            end
        end
    endtask

    // Scoreboard comparison of every DUT output against the model.
    task automatic compare_model();
        logic        e_valid;
        logic [31:0] e_pc, e_instr, e_pf, e_ps;
        e_valid = (mq.size() != 0);
        e_pc    = e_valid ? mq[0].pc : 32'h0;
        e_instr = e_valid ? mq[0].instr : 32'h0;
`ifdef FETCH_PERF_EN
        e_pf = m_fetched;
        e_ps = m_stalls;
`else
        e_pf = 32'h0;
        e_ps = 32'h0;
`endif
        checks++;
        if (if_valid !== e_valid) begin
            errors++;
            $display("FAIL model if_valid @%0t: got %b expected %b", $time, if_valid, e_valid);
        end
        checks++;
        if (if_pc !== e_pc) begin
            errors++;
            $display("FAIL model if_pc @%0t: got %h expected %h", $time, if_pc, e_pc);
        end
        checks++;
        if (if_instr !== e_instr) begin
            errors++;
            $display("FAIL model if_instr @%0t: got %h expected %h", $time, if_instr, e_instr);
        end
        checks++;
        if (imem_a !== m_pc) begin
            errors++;
            $display("FAIL model imem_a @%0t: got %h expected %h", $time, imem_a, m_pc);
        end
        checks++;
        if (halted !== (m_stop && !e_valid)) begin
            errors++;
            $display("FAIL model halted @%0t: got %b expected %b", $time, halted, m_stop && !e_valid);
        end
        checks++;
        if (perf_fetched !== e_pf || perf_stalls !== e_ps) begin
            errors++;
            $display("FAIL model perf @%0t: got %0d/%0d expected %0d/%0d", $time,
                     perf_fetched, perf_stalls, e_pf, e_ps);
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic apply_reset();
        rst_n          = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        fill_imem(0);
        model_reset();
        #3;
        checks++;
        if (if_valid !== 1'b0 || if_pc !== 32'h0 || if_instr !== 32'h0) begin
            errors++;
            $display("FAIL reset_head: got v=%b pc=%h instr=%h expected 0/0/0", if_valid, if_pc, if_instr);
        end
        checks++;
        if (imem_a !== 32'h0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got imem_a=%h halted=%b expected 0/0", imem_a, halted);
        end
        checks++;
        if (perf_fetched !== 32'h0 || perf_stalls !== 32'h0) begin
            errors++;
            $display("FAIL reset_perf: got %0d/%0d expected 0/0", perf_fetched, perf_stalls);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_sequential();
        logic [31:0] prog [3];
        prog[0] = 32'h00500093;
        prog[1] = 32'h00800113;
        prog[2] = 32'h002081b3;
        fill_imem(0);
        for (int i = 0; i < 3; i++) imem[i] = prog[i];
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (if_valid !== 1'b1 || if_pc !== 32'(4 * i) || if_instr !== prog[i]) begin
                errors++;
                $display("FAIL seq_%0d: got v=%b pc=%h instr=%h expected 1/%h/%h",
                         i, if_valid, if_pc, if_instr, 32'(4 * i), prog[i]);
            end
        end
    endtask

    task automatic test_stall();
        fill_imem(0);
        apply_reset();
        step();
        stall = 1'b1;
        repeat (5) step();
        checks++;
        if (if_pc !== 32'h0 || imem_a !== 32'h8) begin
            errors++;
            $display("FAIL stall_hold: got if_pc=%h imem_a=%h expected 0/8", if_pc, imem_a);
        end
`ifdef FETCH_PERF_EN
        checks++;
        if (perf_stalls !== 32'd5 || perf_fetched !== 32'd2) begin
            errors++;
            $display("FAIL stall_perf: got stalls=%0d fetched=%0d expected 5/2", perf_stalls, perf_fetched);
        end
`endif
        stall = 1'b0;
        step();
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h4) begin
            errors++;
            $display("FAIL stall_release1: got v=%b pc=%h expected 1/4", if_valid, if_pc);
        end
        step();
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h8) begin
            errors++;
            $display("FAIL stall_release2: got v=%b pc=%h expected 1/8", if_valid, if_pc);
        end
    endtask

    task automatic test_redirect();
        fill_imem(0);
        apply_reset();
        step();
        stall = 1'b1;
        step();
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h1B;
        step();
        redirect_valid = 1'b0;
        stall          = 1'b0;
        checks++;
        if (imem_a !== 32'h18 || if_valid !== 1'b0) begin
            errors++;
            $display("FAIL redirect_flush: got imem_a=%h v=%b expected 18/0", imem_a, if_valid);
        end
        step();
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h18) begin
            errors++;
            $display("FAIL redirect_target: got v=%b pc=%h expected 1/18", if_valid, if_pc);
        end
        step();
        checks++;
        if (if_pc !== 32'h1C) begin
            errors++;
            $display("FAIL redirect_next: got pc=%h expected 1c", if_pc);
        end
    endtask

    task automatic test_stop();
        bit          seen_24;
        logic [31:0] last_pc, last_instr;
        seen_24    = 1'b0;
        last_pc    = 32'hFFFF_FFFF;
        last_instr = 32'hFFFF_FFFF;
        fill_imem(0);
        imem[8] = 32'h0;
        apply_reset();
        repeat (14) begin
            step();
            if (if_valid) begin
                last_pc    = if_pc;
                last_instr = if_instr;
                if (if_pc == 32'h24) seen_24 = 1'b1;
            end
        end
        checks++;
        if (halted !== 1'b1 || last_pc !== 32'h20 || last_instr !== 32'h0 || seen_24) begin
            errors++;
            $display("FAIL stop_halt: got halted=%b last_pc=%h last_instr=%h seen_24=%b expected 1/20/0/0",
                     halted, last_pc, last_instr, seen_24);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        step();
        redirect_valid = 1'b0;
        checks++;
        if (halted !== 1'b0) begin
            errors++;
            $display("FAIL stop_unhalt: got halted=%b expected 0", halted);
        end
        step();
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h0) begin
            errors++;
            $display("FAIL stop_refetch: got v=%b pc=%h expected 1/0", if_valid, if_pc);
        end
    endtask

    task automatic test_out_of_range();
        fill_imem(0);
        apply_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFC;
        step();
        redirect_valid = 1'b0;
        step();
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'hFC || if_instr !== imem[63]) begin
            errors++;
            $display("FAIL oor_last: got v=%b pc=%h instr=%h expected 1/fc/%h", if_valid, if_pc, if_instr, imem[63]);
        end
        repeat (3) step();
        checks++;
        if (halted !== 1'b1 || if_valid !== 1'b0 || imem_a !== 32'h100) begin
            errors++;
            $display("FAIL oor_halt: got halted=%b v=%b imem_a=%h expected 1/0/100", halted, if_valid, imem_a);
        end
    endtask

    task automatic test_reset_mid();
        fill_imem(0);
        apply_reset();
        step();
        stall = 1'b1;
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (if_valid !== 1'b0 || imem_a !== 32'h0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got v=%b imem_a=%h halted=%b expected 0/0/0", if_valid, imem_a, halted);
        end
        checks++;
        if (perf_fetched !== 32'h0 || perf_stalls !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_perf: got %0d/%0d expected 0/0", perf_fetched, perf_stalls);
        end
        model_reset();
        stall          = 1'b0;
        redirect_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_restart: got v=%b pc=%h expected 1/0", if_valid, if_pc);
        end
    endtask

    task automatic test_random();
        fill_imem(12);
        imem[0] = 32'h00000013;
        apply_reset();
        for (int c = 0; c < 1500; c++) begin
            stall          = ($urandom_range(0, 9) < 3);
            redirect_valid = m_stop ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
            redirect_pc    = $urandom_range(0, 32'h110);
            step();
        end
        redirect_valid = 1'b0;
        stall          = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_stop();
        test_out_of_range();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
